mac_vlg_rx_parse: RTL and testbench
===================================

Name: mac_vlg_rx_parse

Overview:
- Single-clock RX framer directly downstream of the MAC RX clock-domain-crossing FIFO, in the core clock domain.
- Consumes the gap-free per-frame byte stream (data/valid/error) and finds the preamble and SFD.
- Strips the preamble, SFD and 4-byte FCS, checks CRC32 and frame length, and delivers payload bytes (dst MAC onward) with sof/eof and error status to the Ethernet-type parser.

Parameters:
- PRE_MIN, 1, minimum count of 0x55 preamble bytes before 0xD5 for the frame to be accepted.
- PRE_MAX, 7, maximum count of 0x55 bytes; one more 0x55 sends the frame to discard.
- MIN_FRAME, 64, minimum bytes after SFD, including FCS.
- MAX_FRAME, 1518, maximum bytes after SFD, including FCS.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  8  byte from CDC FIFO.
- valid_in  in  1  byte strobe; continuously high for the whole frame; low marks end of frame.
- error_in  in  1  PHY error flag accompanying the byte.
- data_out  out  8  payload byte.
- valid_out  out  1  payload byte strobe.
- sof_out  out  1  first payload byte.
- eof_out  out  1  last payload byte (byte before FCS).
- err_out  out  1  valid with eof_out; OR of err_stat.
- err_stat  out  3  valid with eof_out: {len, phy, fcs}.
- drop_out  out  1  one-cycle pulse when a frame is discarded without output.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0; CRC register 0xFFFFFFFF.
- FSM states:
  - IDLE:
    - valid_in & data_in==0x55 -> PRE, pre_cnt=1.
    - valid_in & any other byte -> DISC.
  - PRE:
    - 0x55 & pre_cnt<PRE_MAX -> pre_cnt++.
    - 0x55 & pre_cnt==PRE_MAX -> DISC.
    - 0xD5 & pre_cnt>=PRE_MIN -> PAY; clear CRC, len counter and flags.
    - Any other byte -> DISC.
    - valid_in low -> IDLE and drop_out pulse.
  - PAY:
    - Each input byte is pushed into a 5-byte delay line, fed into CRC32 and counted (16-bit length counter, saturating at 0xFFFF). error_in is ORed into a sticky phy flag.
    - valid_in low -> IDLE. If len>=5, emit the last payload byte with eof (below); otherwise drop_out pulse.
  - DISC: hold until valid_in low -> IDLE, and pulse drop_out on that cycle. A frame that enters DISC produces no valid_out at all.
- Output timing (all registered):
  - Payload byte k (k=0 is the first byte after SFD) appears on data_out with valid_out=1 one cycle after byte k+5 is sampled.
  - sof_out=1 with byte 0.
  - Last payload byte: presented one cycle after the first valid_in=0 cycle, with eof_out=1 and err_out/err_stat set.
  - valid_out is therefore continuous within a frame.
  - Frame with exactly 5 bytes after SFD: a single output byte with sof_out=eof_out=1.
- CRC32 rules:
  - Reflected, poly 0xEDB88320, init 0xFFFFFFFF, LSB first.
  - Computed over every byte after SFD, including the FCS.
  - fcs error = (register != 0xDEBB20E3) at end of frame.
- Length error: len<MIN_FRAME or len>MAX_FRAME. Oversize frames are still forwarded in full, flagged at eof.
- Outputs outside a payload byte: data_out holds its last value; sof_out, eof_out, err_out, err_stat are 0.
- A new preamble may start the cycle after valid_in falls. The eof emission cycle and IDLE acceptance of a new byte may coincide; the two are independent.
- Asynchronous reset mid-frame: outputs clear immediately, FSM returns to IDLE, and the rest of that frame is handled as a new frame.

Test Plan:
- 7×0x55, 0xD5, 60-byte payload 0x00..0x3B, correct FCS -> 60 valid_out bytes matching the payload; sof on 0x00; eof on 0x3B; err_stat=000; first output 6 cycles after the first post-SFD byte.
- Same frame with one payload bit flipped -> eof with err_stat=001, err_out=1.
- error_in high on payload byte 10 -> err_stat=010 at eof; data stream unchanged.
- 0x55 ×3 then 0xAA -> no valid_out; a single drop_out pulse when valid_in falls. 8×0x55 then 0xD5 -> same result.
- 40-byte payload with correct FCS (44 bytes after SFD) -> forwarded; err_stat=100. 1600-byte frame -> forwarded; err_stat=100.
- Back-to-back frames separated by a 1-cycle valid_in gap, and rst asserted mid-payload -> both frames are parsed independently; on reset, all outputs go to 0 asynchronously with no eof.

Source files
------------

// File: rtl/mac_vlg_rx_parse.sv
// RX framer behind the MAC RX CDC FIFO: strips preamble/SFD/FCS, checks CRC32
// and length, and forwards payload bytes with sof/eof and error status.
module mac_vlg_rx_parse #(
  parameter int PRE_MIN   = 1,
  parameter int PRE_MAX   = 7,
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  input  logic       error_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       sof_out,
  output logic       eof_out,
  output logic       err_out,
  output logic [2:0] err_stat,
  output logic       drop_out
);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_PAY, S_DISC} state_t;

  localparam logic [3:0]  PRE_MIN_C = 4'(PRE_MIN);
  localparam logic [3:0]  PRE_MAX_C = 4'(PRE_MAX);
  localparam logic [15:0] MIN_LEN_C = 16'(MIN_FRAME);
  localparam logic [15:0] MAX_LEN_C = 16'(MAX_FRAME);
  localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESID = 32'hDEBB_20E3;

  state_t      state_q, state_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [15:0] len_q, len_d;
  logic [31:0] crc_q, crc_d;
  logic        phy_q, phy_d;
  logic [7:0]  dl_q [5];
  logic [7:0]  dl_d [5];
  logic [7:0]  data_out_q, data_out_d;
  logic        valid_out_q, valid_out_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic        err_q, err_d;
  logic [2:0]  err_stat_q, err_stat_d;
  logic        drop_q, drop_d;
  logic [2:0]  stat_w;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  // The 5-deep delay line hides the 4 FCS bytes plus one byte of lookahead so
  // the last payload byte can be tagged with eof once valid_in drops.
  assign stat_w = {(len_q < MIN_LEN_C) || (len_q > MAX_LEN_C), phy_q, crc_q != CRC_RESID};

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    len_d       = len_q;
    crc_d       = crc_q;
    phy_d       = phy_q;
    dl_d        = dl_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    err_d       = 1'b0;
    err_stat_d  = 3'b000;
    drop_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          if (data_in == 8'h55) begin
            state_d   = S_PRE;
            pre_cnt_d = 4'd1;
          end else begin
            state_d = S_DISC;
          end
        end
      end
      S_PRE: begin
        if (!valid_in) begin
          state_d = S_IDLE;
          drop_d  = 1'b1;
        end else if (data_in == 8'h55) begin
          if (pre_cnt_q < PRE_MAX_C) pre_cnt_d = pre_cnt_q + 4'd1;
          else                       state_d   = S_DISC;
        end else if (data_in == 8'hD5 && pre_cnt_q >= PRE_MIN_C) begin
          state_d = S_PAY;
          crc_d   = CRC_INIT;
          len_d   = 16'd0;
          phy_d   = 1'b0;
        end else begin
          state_d = S_DISC;
        end
      end
      S_PAY: begin
        if (valid_in) begin
          dl_d[0] = data_in;
          for (int i = 1; i < 5; i++) dl_d[i] = dl_q[i-1];
          crc_d = crc32_byte(crc_q, data_in);
          len_d = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
          phy_d = phy_q | error_in;
          if (len_q >= 16'd5) begin
            valid_out_d = 1'b1;
            data_out_d  = dl_q[4];
            sof_d       = (len_q == 16'd5);
          end
        end else begin
          state_d = S_IDLE;
          if (len_q >= 16'd5) begin
            valid_out_d = 1'b1;
            data_out_d  = dl_q[4];
            sof_d       = (len_q == 16'd5);
            eof_d       = 1'b1;
            err_stat_d  = stat_w;
            err_d       = |stat_w;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      S_DISC: begin
        if (!valid_in) begin
          state_d = S_IDLE;
          drop_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pre_cnt_q   <= 4'd0;
      len_q       <= 16'd0;
      crc_q       <= CRC_INIT;
      phy_q       <= 1'b0;
      data_out_q  <= 8'd0;
      valid_out_q <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      err_q       <= 1'b0;
      err_stat_q  <= 3'b000;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      len_q       <= len_d;
      crc_q       <= crc_d;
      phy_q       <= phy_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      err_q       <= err_d;
      err_stat_q  <= err_stat_d;
      drop_q      <= drop_d;
    end
  end

  for (genvar gi = 0; gi < 5; gi++) begin : g_dl
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) dl_q[gi] <= 8'd0;
      else      dl_q[gi] <= dl_d[gi];
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign sof_out   = sof_q;
  assign eof_out   = eof_q;
  assign err_out   = err_q;
  assign err_stat  = err_stat_q;
  assign drop_out  = drop_q;

endmodule

// File: tb/tb_mac_vlg_rx_parse.sv
// Directed bench for mac_vlg_rx_parse: builds frames with a bench-side CRC32,
// drives them, and checks the forwarded payload, framing flags and status.
module tb_mac_vlg_rx_parse;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'd0;
  logic       valid_in = 1'b0;
  logic       error_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out, sof_out, eof_out, err_out, drop_out;
  logic [2:0] err_stat;

  mac_vlg_rx_parse dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .error_in(error_in),
    .data_out(data_out), .valid_out(valid_out), .sof_out(sof_out), .eof_out(eof_out),
    .err_out(err_out), .err_stat(err_stat), .drop_out(drop_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] out_data[$];
  logic       out_sof[$];
  logic       out_eof[$];
  logic [2:0] eof_stat[$];
  logic       eof_err[$];
  int         sof_cyc[$];
  int         sof_cnt = 0, eof_cnt = 0, drop_cnt = 0, side_bad = 0;

  always @(negedge clk) begin
    if (valid_out) begin
      out_data.push_back(data_out);
      out_sof.push_back(sof_out);
      out_eof.push_back(eof_out);
      if (sof_out) begin sof_cnt++; sof_cyc.push_back(cyc); end
      if (eof_out) begin eof_cnt++; eof_stat.push_back(err_stat); eof_err.push_back(err_out); end
    end else if (sof_out || eof_out || err_out || err_stat != 3'b000) begin
      side_bad++;
    end
    if (drop_out) drop_cnt++;
  end

  int passed = 0, total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r = c;
    for (int j = 0; j < 8; j++) begin
      logic fb = r[0] ^ b[j];
      r = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  logic [7:0] stim[$];
  logic [7:0] exp_pay[$];
  int err_at = -1, pay_start = 0, t0 = 0;
  int b_data, b_sof, b_eof, b_drop, b_sofq;

  task automatic build(input int npre, input int npay, input int flip);
    logic [31:0] crc = 32'hFFFFFFFF;
    logic [31:0] fcs;
    stim.delete(); exp_pay.delete();
    for (int i = 0; i < npre; i++) stim.push_back(8'h55);
    stim.push_back(8'hD5);
    pay_start = npre + 1;
    for (int i = 0; i < npay; i++) begin
      exp_pay.push_back(i[7:0]);
      stim.push_back(i[7:0]);
      crc = crc_bits(crc, i[7:0]);
    end
    fcs = ~crc;
    for (int k = 0; k < 4; k++) stim.push_back(fcs[8*k +: 8]);
    if (flip >= 0) stim[pay_start+flip] = stim[pay_start+flip] ^ 8'h08;
  endtask

  task automatic drive(input int from, input int to, input bit finish);
    for (int i = from; i < to; i++) begin
      @(posedge clk); #1;
      valid_in = 1'b1; data_in = stim[i]; error_in = (i == err_at);
      if (i == pay_start) t0 = cyc;
    end
    if (finish) begin
      @(posedge clk); #1;
      valid_in = 1'b0; error_in = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark();
    b_data = out_data.size(); b_sof = sof_cnt; b_eof = eof_cnt;
    b_drop = drop_cnt; b_sofq = sof_cyc.size();
  endtask

  task automatic check_frame(input string tag, input int exp_n, input logic [2:0] exp_stat);
    int n = out_data.size() - b_data;
    int mism = 0;
    chk({tag, ".count"}, n, exp_n);
    chk({tag, ".sofs"}, sof_cnt - b_sof, 1);
    chk({tag, ".eofs"}, eof_cnt - b_eof, 1);
    chk({tag, ".drop"}, drop_cnt - b_drop, 0);
    if (n == exp_n && n > 0) begin
      for (int i = 0; i < n; i++) if (out_data[b_data+i] !== exp_pay[i]) mism++;
      chk({tag, ".data"}, mism, 0);
      chk({tag, ".sof_first"}, out_sof[b_data], 1);
      chk({tag, ".eof_last"}, out_eof[b_data+n-1], 1);
    end
    if (eof_cnt > b_eof) begin
      chk({tag, ".stat"}, eof_stat[b_eof], exp_stat);
      chk({tag, ".err"}, eof_err[b_eof], |exp_stat);
    end
  endtask

  task automatic check_drop(input string tag);
    chk({tag, ".count"}, out_data.size() - b_data, 0);
    chk({tag, ".drop"}, drop_cnt - b_drop, 1);
  endtask

  initial begin
    #2 rst = 1'b0;
    idle(3);
    chk("rst.valid", valid_out, 0);
    chk("rst.flags", {sof_out, eof_out, err_out, drop_out}, 0);
    chk("rst.stat", err_stat, 0);
    chk("rst.data", data_out, 0);
    rst = 1'b1;
    idle(2);

    // Nominal 60-byte payload
    mark(); build(7, 60, -1); drive(0, stim.size(), 1); idle(4);
    check_frame("good", 60, 3'b000);
    if (sof_cyc.size() > b_sofq) chk("good.latency", sof_cyc[b_sofq] - t0, 6);
    $display("txn good frame: %0d bytes out", out_data.size() - b_data);

    mark(); build(7, 60, 17); exp_pay[17] = exp_pay[17] ^ 8'h08;
    drive(0, stim.size(), 1); idle(4);
    check_frame("fcs", 60, 3'b001);
    $display("txn bit-flipped frame");

    mark(); build(7, 60, -1); err_at = pay_start + 10;
    drive(0, stim.size(), 1); idle(4); err_at = -1;
    check_frame("phy", 60, 3'b010);
    $display("txn phy-error frame");

    mark(); stim = '{8'h55, 8'h55, 8'h55, 8'hAA}; pay_start = 99;
    drive(0, 4, 1); idle(4);
    check_drop("badpre");
    $display("txn 3x55+AA discard");

    mark(); build(8, 60, -1); drive(0, stim.size(), 1); idle(4);
    check_drop("longpre");
    $display("txn 8x55 preamble discard");

    mark(); build(7, 40, -1); drive(0, stim.size(), 1); idle(4);
    check_frame("runt", 40, 3'b100);
    $display("txn 44-byte runt");

    mark(); build(7, 1596, -1); drive(0, stim.size(), 1); idle(4);
    check_frame("giant", 1596, 3'b100);
    $display("txn 1600-byte giant");

    mark(); build(1, 1, -1); drive(0, stim.size(), 1); idle(4);
    check_frame("min5", 1, 3'b100);
    if (out_eof.size() > b_data) chk("min5.sof_eof", {out_sof[b_data], out_eof[b_data]}, 2'b11);
    $display("txn 5-byte frame");

    mark(); build(7, 0, -1); stim = stim[0:10]; drive(0, stim.size(), 1); idle(4);
    check_drop("short");
    $display("txn 3-byte frame after SFD");

    // Two frames with a single idle cycle between them
    mark(); build(7, 60, -1); drive(0, stim.size(), 1); drive(0, stim.size(), 1); idle(4);
    chk("b2b.count", out_data.size() - b_data, 120);
    chk("b2b.sofs", sof_cnt - b_sof, 2);
    chk("b2b.eofs", eof_cnt - b_eof, 2);
    if (eof_cnt - b_eof == 2) chk("b2b.stats", {eof_stat[b_eof], eof_stat[b_eof+1]}, 0);
    if (out_data.size() - b_data == 120) begin
      chk("b2b.second_first", out_data[b_data+60], 8'h00);
      chk("b2b.second_sof", out_sof[b_data+60], 1);
    end
    $display("txn back-to-back frames");

    // Reset in the middle of a payload
    build(7, 60, -1); drive(0, 28, 0);
    #2;
    chk("mid.pre_valid", valid_out, 1);
    rst = 1'b0; #1;
    chk("mid.valid", valid_out, 0);
    chk("mid.flags", {sof_out, eof_out, err_out, drop_out}, 0);
    chk("mid.data", data_out, 0);
    @(posedge clk); #1; rst = 1'b1;
    mark(); drive(28, stim.size(), 1); idle(4);
    check_drop("mid.rest");
    chk("mid.eofs", eof_cnt - b_eof, 0);
    $display("txn reset mid-payload");

    mark(); build(7, 60, -1); drive(0, stim.size(), 1); idle(4);
    check_frame("after", 60, 3'b000);
    chk("side.flags", side_bad, 0);
    $display("txn frame after reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
